usr_seq_ctrl: RTL
=================

// Module: usr_seq_ctrl
// PURPOSE
//  Command sequencer for the universal shift register (USR) datapath.
//  Accepts one command at a time over a valid/ready handshake and drives the USR controls: s, I, leftshift, rightshift.
//  Supported commands: parallel load, shift right/left by N, rotate right by N.
//  Sits between a host/test controller and one USR instance. USR OUT is fed back for rotate.
// PARAMETERS
//  WIDTH  8  USR data width
//  CW     4  width of shift-count field (max count 2**CW-1)
// PORTS
//  clk         in   1      clock, rising-edge
//  reset       in   1      synchronous, active-high
//  cmd_valid   in   1      command present
//  cmd_ready   out  1      controller can accept a command
//  cmd_op      in   2      00 LOAD, 01 SHR, 10 SHL, 11 ROTR
//  cmd_cnt     in   CW     shift/rotate count (ignored for LOAD)
//  cmd_data    in   WIDTH  parallel load word (LOAD only)
//  cmd_sin     in   1      serial fill bit for SHR/SHL
//  usr_q       in   WIDTH  USR OUT feedback
//  s           out  2      USR mode: 00 hold, 01 shift right, 10 shift left, 11 load
//  usr_i       out  WIDTH  USR parallel input I
//  leftshift   out  1      USR serial-in, enters LSB on a left shift
//  rightshift  out  1      USR serial-in, enters MSB on a right shift
//  busy        out  1      command in progress (EXEC or DONE)
//  done        out  1      one-cycle completion pulse
// BEHAVIOUR
//  Reset (synchronous, priority over all inputs):
//   - state=IDLE; s=00; usr_i=0; leftshift=0; rightshift=0; busy=0; done=0; count=0.
//  Output timing:
//   - All outputs are registered except rightshift in ROTR.
//   - ROTR: rightshift = usr_q[0], combinational.
//  Handshake:
//   - cmd_ready=1 only in IDLE.
//   - A command is accepted on an edge with cmd_valid&&cmd_ready; op, cnt, data and sin are latched at that edge.
//   - Command inputs are ignored at all other times.
//  FSM states: IDLE, EXEC, DONE.
//  IDLE:
//   - s=00.
//   - Accept LOAD -> EXEC.
//   - Accept SHR/SHL/ROTR with cnt>0 -> EXEC, remaining count = cnt.
//   - Accept SHR/SHL/ROTR with cnt==0 -> DONE directly; no shift cycle is issued.
//  EXEC, LOAD:
//   - Exactly 1 cycle with s=11 and usr_i=latched data, then DONE.
//  EXEC, SHR/SHL/ROTR:
//   - SHR: s=01; SHL: s=10; ROTR: s=01.
//   - Mode is held for exactly cnt cycles; the count decrements each cycle and the FSM goes to DONE when it reaches 1.
//   - SHR: rightshift=sin. SHL: leftshift=sin. ROTR: rightshift=usr_q[0].
//   - The unused serial input is driven 0.
//   - usr_i holds its last value (don't-care to the USR outside load).
//  DONE:
//   - 1 cycle with s=00, done=1, cmd_ready=0, then IDLE.
//  Latency, accept edge to done high:
//   - LOAD: 2 cycles.
//   - Shift ops: cnt+1 cycles (1 cycle if cnt==0).
//  Back-to-back: minimum command spacing is 1 IDLE cycle after DONE.
//  cnt > WIDTH is legal:
//   - SHR/SHL fill the word entirely with sin.
//   - ROTR wraps modulo WIDTH.
//  Reset mid-EXEC:
//   - Abort immediately; no done pulse; s=00 the following cycle.
//   - USR contents are whatever was shifted before the abort.
//  busy = (state != IDLE).
// TESTING
//  1. reset=1 for 2 clk -> s=00, busy=0, done=0, cmd_ready=1, leftshift=rightshift=0.
//  2. LOAD data=8'b00001010 -> s=11 for 1 cycle with usr_i=8'h0A; done 2 cycles after accept; USR OUT=8'h0A.
//  3. SHR cnt=2 sin=0 from 8'h0A -> s=01 for exactly 2 cycles; OUT=8'h02; done at accept+3.
//  4. ROTR cnt=3 from 8'h0A -> OUT=8'h41. SHL cnt=9 sin=1 -> OUT=8'hFF.
//  5. SHL cnt=0 -> no cycle with s=10; done at accept+1. cmd_valid held high through DONE -> not re-accepted until IDLE.
//  6. SHL cnt=5, reset at 2nd EXEC cycle -> next cycle s=00, busy=0, done never pulses; a new command is accepted right after.

Source files
------------

// File: rtl/usr_seq_ctrl.sv
// Command sequencer for a universal shift register.
// Turns load/shift/rotate commands into per-cycle USR mode and serial-in controls.
module usr_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CW-1:0]    cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_sin,
  input  logic [WIDTH-1:0] usr_q,
  output logic [1:0]       s,
  output logic [WIDTH-1:0] usr_i,
  output logic             leftshift,
  output logic             rightshift,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SHR  = 2'b01;
  localparam logic [1:0] OP_SHL  = 2'b10;
  localparam logic [1:0] OP_ROTR = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sin_q, sin_d;
  logic [WIDTH-1:0] usr_i_q, usr_i_d;
  logic [1:0]       s_q, s_d;
  logic             ls_q, ls_d;
  logic             rs_q, rs_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             rot_act;
  logic             unused_fb;

  assign accept = cmd_valid && ready_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    sin_d   = sin_q;
    usr_i_d = usr_i_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = cmd_op;
          sin_d = cmd_sin;
          cnt_d = cmd_cnt;
          if (cmd_op == OP_LOAD) begin
            usr_i_d = cmd_data;
            cnt_d   = '0;
            state_d = ST_EXEC;
          end else if (cmd_cnt == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (op_q == OP_LOAD) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they leave a flop.
  always_comb begin
    s_d     = 2'b00;
    ls_d    = 1'b0;
    rs_d    = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
    if (state_d == ST_EXEC) begin
      unique case (op_d)
        OP_LOAD: s_d = 2'b11;
        OP_SHR: begin
          s_d  = 2'b01;
          rs_d = sin_d;
        end
        OP_SHL: begin
          s_d  = 2'b10;
          ls_d = sin_d;
        end
        OP_ROTR: s_d = 2'b01;
        default: s_d = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      cnt_q   <= '0;
      sin_q   <= 1'b0;
      usr_i_q <= '0;
      s_q     <= 2'b00;
      ls_q    <= 1'b0;
      rs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      sin_q   <= sin_d;
      usr_i_q <= usr_i_d;
      s_q     <= s_d;
      ls_q    <= ls_d;
      rs_q    <= rs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // Rotate feeds the outgoing LSB straight back into the MSB.
  assign rot_act    = (state_q == ST_EXEC) && (op_q == OP_ROTR);
  assign rightshift = rot_act ? usr_q[0] : rs_q;
  assign unused_fb  = ^usr_q[WIDTH-1:1];

  assign s         = s_q;
  assign usr_i     = usr_i_q;
  assign leftshift = ls_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = ready_q;

endmodule
